// File: rtl/cpu_pkg.sv
// Shared CPU definitions: reset vector, stage1->stage2 bus width, fetch state encoding.
package cpu_pkg;

  localparam logic [31:0] RESET_PC     = 32'hbfc0_0000;
  localparam int          STAGE1_BUS_W = 64;

  typedef enum logic [1:0] {
    REQ  = 2'd0,
    WAIT = 2'd1,
    HOLD = 2'd2
  } fetch_state_e;

endpackage

// File: rtl/if_stage1.sv
// Pipeline head: owns the PC, issues one outstanding instruction fetch at a time
// and hands {pc, inst} to stage 2 under a valid/allowin handshake.
//
//   state | meaning
//   REQ   | fetch request driven at r_fetch_pc, waiting for addr_ok
//   WAIT  | request accepted, waiting for data_ok (dropped if r_cancel)
//   HOLD  | instruction buffered on the bus, waiting for stage2 allowin
module if_stage1
  import cpu_pkg::*;
#(
  parameter logic [31:0] RESET_PC = cpu_pkg::RESET_PC,
  parameter int          BUS_W    = STAGE1_BUS_W
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             stage2_allowin_in,
  output logic             stage1_to_stage2_valid_out,
  output logic [BUS_W-1:0] stage1_to_stage2_bus_out,
  input  logic             br_valid_in,
  input  logic [31:0]      br_target_in,
  output logic             inst_req_out,
  output logic [31:0]      inst_addr_out,
  input  logic             inst_addr_ok_in,
  input  logic             inst_data_ok_in,
  input  logic [31:0]      inst_rdata_in
);

  fetch_state_e     r_state, w_state_nxt;
  logic [31:0]      r_fetch_pc, w_fetch_pc_nxt;
  logic [31:0]      r_redir_pc, w_redir_pc_nxt;
  logic             r_redir_pend, w_redir_pend_nxt;
  logic             r_cancel, w_cancel_nxt;
  logic [BUS_W-1:0] r_bus, w_bus_nxt;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state      <= REQ;
      r_fetch_pc   <= RESET_PC;
      r_redir_pc   <= '0;
      r_redir_pend <= 1'b0;
      r_cancel     <= 1'b0;
      r_bus        <= '0;
    end else begin
      r_state      <= w_state_nxt;
      r_fetch_pc   <= w_fetch_pc_nxt;
      r_redir_pc   <= w_redir_pc_nxt;
      r_redir_pend <= w_redir_pend_nxt;
      r_cancel     <= w_cancel_nxt;
      r_bus        <= w_bus_nxt;
    end
  end

  always_comb begin
    w_state_nxt      = r_state;
    w_fetch_pc_nxt   = r_fetch_pc;
    w_redir_pc_nxt   = r_redir_pc;
    w_redir_pend_nxt = r_redir_pend;
    w_cancel_nxt     = r_cancel;
    w_bus_nxt        = r_bus;

    // A same-cycle redirect is folded in here so every state sees the newest target.
    if (br_valid_in) begin
      w_redir_pc_nxt   = br_target_in;
      w_redir_pend_nxt = 1'b1;
    end

    case (r_state)
      REQ: begin
        if (br_valid_in) w_cancel_nxt = 1'b1;
        if (inst_addr_ok_in) w_state_nxt = WAIT;
      end
      WAIT: begin
        if (br_valid_in) w_cancel_nxt = 1'b1;
        if (inst_data_ok_in) begin
          if (r_cancel || br_valid_in) begin
            w_state_nxt      = REQ;
            w_cancel_nxt     = 1'b0;
            w_redir_pend_nxt = 1'b0;
            w_fetch_pc_nxt   = w_redir_pc_nxt;
          end else begin
            w_state_nxt = HOLD;
            w_bus_nxt   = {r_fetch_pc, inst_rdata_in};
          end
        end
      end
      HOLD: begin
        // Redirect without allowin drops the held instruction outright.
        if (stage2_allowin_in || br_valid_in) begin
          w_state_nxt      = REQ;
          w_redir_pend_nxt = 1'b0;
          w_cancel_nxt     = 1'b0;
          w_fetch_pc_nxt   = (br_valid_in || r_redir_pend) ? w_redir_pc_nxt
                                                           : r_fetch_pc + 32'd4;
        end
      end
      default: w_state_nxt = REQ;
    endcase
  end

  assign inst_req_out               = (r_state == REQ);
  assign inst_addr_out              = r_fetch_pc;
  assign stage1_to_stage2_valid_out = (r_state == HOLD);
  assign stage1_to_stage2_bus_out   = r_bus;

endmodule

// File: doc/if_stage1.md
# if_stage1

Pipeline head stage that fetches instructions from the instruction SRAM-like port and issues them into stage 2. It sits upstream of `pipeline_2`:
- It drives `stage1_to_stage2_valid`/`bus` and consumes `stage2_allowin`.
- It owns the PC register and sequential-PC generation.
- It accepts branch redirects from later stages.
- It allows one outstanding fetch.

## Interface
Parameters:
- `RESET_PC`, default 32'hbfc0_0000: first fetch address after reset.
- `BUS_W`, default 64: stage1→stage2 bus width, packed as {pc[31:0], inst[31:0]}.

Ports:
- `clk` in 1: single clock.
- `rst` in 1: synchronous, active-high reset.
- `stage2_allowin_in` in 1: stage 2 accepts data at the next edge.
- `stage1_to_stage2_valid_out` out 1: bus holds a valid fetched instruction.
- `stage1_to_stage2_bus_out` out BUS_W: {pc, inst}.
- `br_valid_in` in 1: one-cycle redirect pulse.
- `br_target_in` in 32: redirect target.
- `inst_req_out` out 1: fetch request.
- `inst_addr_out` out 32: fetch address.
- `inst_addr_ok_in` in 1: request accepted this cycle.
- `inst_data_ok_in` in 1: response data valid this cycle.
- `inst_rdata_in` in 32: response data.

## Operation
The block is a state machine with three states: REQ, WAIT and HOLD. Reset puts it in REQ with `fetch_pc = RESET_PC`, `cancel = 0` and `redir_pend = 0`.

Outputs by state:
- `inst_req_out = (state==REQ)`.
- `inst_addr_out = fetch_pc`. The address is stable while a request is held and not yet accepted.
- `stage1_to_stage2_valid_out = (state==HOLD)`.

State transitions:
- REQ → WAIT on `inst_addr_ok_in`.
- WAIT on `inst_data_ok_in`:
  - If `cancel=1`: discard the response, clear `cancel`, and go to REQ.
  - Otherwise: latch {fetch_pc, inst_rdata_in} into the output buffer and go to HOLD.
- HOLD on `stage2_allowin_in`: the handshake completes. Go to REQ with `fetch_pc` set to `redir_pend ? redir_pc : fetch_pc+4`, then clear `redir_pend`.

Redirect handling: on `br_valid_in`, set `redir_pc = br_target_in` and `redir_pend = 1`. A later redirect overwrites an earlier pending one. The effect depends on the state:
- REQ: set `cancel`. The request continues with the old address and its response is dropped in WAIT.
- WAIT: set `cancel`.
- HOLD without allowin: the held instruction is dropped. Next cycle: REQ, `fetch_pc = br_target_in`, valid deasserted.
- HOLD with allowin in the same cycle: stage 2 takes the instruction; flushing it is stage 2's responsibility. The next fetch uses `br_target_in`.

Whenever the block leaves WAIT via a cancelled response, `fetch_pc = redir_pc` and `redir_pend` is cleared.

Arithmetic: `fetch_pc+4` is modulo 2^32, so 32'hffff_fffc wraps to 0. No alignment checking is done.

## Timing
State after reset (first edge with `rst`=1):
- state REQ.
- `stage1_to_stage2_valid_out` = 0.
- `stage1_to_stage2_bus_out` = 0.
- `inst_req_out` = 1 from the first cycle after `rst` deasserts, with `inst_addr_out` = RESET_PC.

Latency:
- With `addr_ok` in cycle n and `data_ok` in cycle n+1, valid is asserted in cycle n+2.
- Best-case issue rate is one instruction every 3 cycles. Throughput optimisation is out of scope.

Handshake rules:
- Valid is not gated by allowin.
- The bus is stable while valid=1 and allowin=0.

Boundary conditions:
- `rst` mid-transaction: state returns to REQ at RESET_PC. A late `data_ok` arriving in REQ is ignored.
- `data_ok` arriving in REQ or HOLD is ignored.
- `br_valid_in` in the same cycle as `inst_addr_ok_in`: the request is accepted and cancelled.
- `br_valid_in` in the same cycle as `inst_data_ok_in` in WAIT: the response is dropped.

## Structure
- Shared package `cpu_pkg` holds: `RESET_PC`, `STAGE1_BUS_W = 64`, and the state enum (REQ, WAIT, HOLD).
- The block is a single flat module. No sub-module is warranted.

## Test plan
- Reset then stream: `addr_ok`/`data_ok` always 1, `allowin` always 1.
  - Required: addresses bfc00000, bfc00004, bfc00008.
  - Required: bus = {pc, rdata}, each valid for exactly 1 cycle.
- Backpressure: `allowin`=0 for 5 cycles during HOLD.
  - Required: valid and bus are held constant.
  - Required: `inst_req_out` = 0 throughout.
  - Required: the next request goes out the cycle after `allowin`=1.
- Redirect in WAIT: target 8000_0040, `data_ok` arrives 3 cycles later with 0xdead_beef.
  - Required: the response is not presented.
  - Required: the next `inst_addr_out` = 8000_0040.
- Redirect in HOLD with `allowin`=0.
  - Required: valid drops the next cycle.
  - Required: the fetch goes to the target.
  - Redirect in HOLD with `allowin`=1: the handshake completes and the next address is the target.
- `addr_ok` stalled for 4 cycles.
  - Required: `inst_addr_out` is stable.
  - A redirect during the stall: the old address is still accepted, its response is dropped, then the target is fetched.
- Wrap and reset:
  - `fetch_pc` = ffff_fffc → next fetch address is 0000_0000.
  - `rst` asserted while in WAIT → restart at bfc00000, with the stale `data_ok` ignored.
